// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR flip-flops with a configurable S=R=1 policy.
// Q/invalid are registered; Qbar is the combinational complement of Q.
module sr_flip_flop #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned BOTH_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] invalid
);

    typedef enum logic [1:0] {
        BothHold   = 2'd0,
        BothSet    = 2'd1,
        BothReset  = 2'd2,
        BothToggle = 2'd3
    } both_mode_e;

    // Out-of-range policy values fall back to hold.
    localparam both_mode_e Mode = (BOTH_MODE > 3) ? BothHold : both_mode_e'(BOTH_MODE[1:0]);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] invalid_q, invalid_d;

    always_comb begin
        q_d       = q_q;
        invalid_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case ({S[i], R[i]})
                2'b10: q_d[i] = 1'b1;
                2'b01: q_d[i] = 1'b0;
                2'b11: begin
                    invalid_d[i] = 1'b1;
                    case (Mode)
                        BothSet:    q_d[i] = 1'b1;
                        BothReset:  q_d[i] = 1'b0;
                        BothToggle: q_d[i] = ~q_q[i];
                        default:    q_d[i] = q_q[i];
                    endcase
                end
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            invalid_q <= '0;
        end else begin
            q_q       <= q_d;
            invalid_q <= invalid_d;
        end
    end

    assign Q       = q_q;
    assign Qbar    = ~q_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Scoreboard bench: one 1-bit instance plus 4-bit instances for each S=R=1 policy
// (0..3 and out-of-range 5), all driven from the same S/R/rst_n.
module tb_sr_flip_flop;

    logic       clk;
    logic       rst_n;
    logic [3:0] s, r;

    logic       q1, qb1, inv1;
    logic [3:0] q4   [5];
    logic [3:0] qb4  [5];
    logic [3:0] inv4 [5];

    int modes [5] = '{0, 1, 2, 3, 5};

    typedef struct {
        logic [4:0][3:0] q;
        logic [3:0]      inv;
        string           name;
    } exp_t;

    exp_t       sb [$];
    logic [3:0] mq [5];
    int n_tests = 0;
    int n_fail  = 0;

    sr_flip_flop #(.WIDTH(1), .BOTH_MODE(0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .S(s[0]), .R(r[0]), .Q(q1), .Qbar(qb1), .invalid(inv1)
    );

    for (genvar g = 0; g < 4; g++) begin : g_mode
        sr_flip_flop #(.WIDTH(4), .BOTH_MODE(g)) u_m (
            .clk(clk), .rst_n(rst_n), .S(s), .R(r), .Q(q4[g]), .Qbar(qb4[g]), .invalid(inv4[g])
        );
    end

    sr_flip_flop #(.WIDTH(4), .BOTH_MODE(5)) u_m5 (
        .clk(clk), .rst_n(rst_n), .S(s), .R(r), .Q(q4[4]), .Qbar(qb4[4]), .invalid(inv4[4])
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [3:0] model_next(int mode, logic [3:0] q, logic [3:0] sv,
                                              logic [3:0] rv);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) begin
            if (sv[b] && !rv[b])      n[b] = 1'b1;
            else if (!sv[b] && rv[b]) n[b] = 1'b0;
            else if (sv[b] && rv[b])  n[b] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 :
                                             (mode == 3) ? ~q[b] : q[b];
            else                      n[b] = q[b];
        end
        return n;
    endfunction

    // Drive at the falling edge, queue the expected post-edge state, settle past the rising edge.
    task automatic drive_edge(string name, logic [3:0] sv, logic [3:0] rv);
        exp_t e;
        @(negedge clk);
        s = sv;
        r = rv;
        for (int i = 0; i < 5; i++) begin
            mq[i]  = model_next(modes[i], mq[i], sv, rv);
            e.q[i] = mq[i];
        end
        e.inv  = sv & rv;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n = 1'b0;
        s = 4'hF;
        r = 4'hF;
        #3;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({q4[i], qb4[i], inv4[i]} !== {4'h0, 4'hF, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_async m%0d: Q/Qbar/inv got %b/%b/%b exp 0000/1111/0000",
                         modes[i], q4[i], qb4[i], inv4[i]);
            end
        end
        // S=R=1 across an edge while in reset must be ignored.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({q4[i], qb4[i], inv4[i]} !== {4'h0, 4'hF, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_edge m%0d: Q/Qbar/inv got %b/%b/%b exp 0000/1111/0000",
                         modes[i], q4[i], qb4[i], inv4[i]);
            end
        end
        n_tests++;
        if ({q1, qb1, inv1} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_w1: Q/Qbar/inv got %b%b%b exp 010", q1, qb1, inv1);
        end
        for (int i = 0; i < 5; i++) mq[i] = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        s = 4'hF;
        r = 4'h0;
        #1;
        n_tests++;
        if ({q1, qb1} !== 2'b01) begin
            n_fail++;
            $display("FAIL release_no_update: Q/Qbar got %b%b exp 01", q1, qb1);
        end
        for (int i = 0; i < 5; i++) begin
            mq[i]  = model_next(modes[i], mq[i], s, r);
            e.q[i] = mq[i];
        end
        e.inv  = 4'h0;
        e.name = "release_first_edge";
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({q1, qb1, inv1} !== {e.q[0][0], ~e.q[0][0], e.inv[0]}) begin
            n_fail++;
            $display("FAIL %s w1: Q/Qbar/inv got %b%b%b exp %b%b%b", e.name, q1, qb1, inv1,
                     e.q[0][0], ~e.q[0][0], e.inv[0]);
        end
    endtask

    task automatic test_set_reset_hold;
        exp_t e;
        logic [3:0] sv [3] = '{4'hF, 4'h0, 4'h0};
        logic [3:0] rv [3] = '{4'h0, 4'hF, 4'h0};
        string      nm [3] = '{"set", "reset_via_r", "hold"};
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 5; k++) begin
                drive_edge(nm[p], sv[p], rv[p]);
                if (p == 2 && k == 2) begin
                    // Mid-cycle glitch on S must not reach Q.
                    #3 s = 4'hF;
                    #2 s = 4'h0;
                end
                e = sb.pop_front();
                for (int i = 0; i < 5; i++) begin
                    n_tests++;
                    if ({q4[i], qb4[i], inv4[i]} !== {e.q[i], ~e.q[i], e.inv}) begin
                        n_fail++;
                        $display("FAIL %s m%0d edge%0d: Q/Qbar/inv got %b/%b/%b exp %b/%b/%b",
                                 e.name, modes[i], k, q4[i], qb4[i], inv4[i], e.q[i], ~e.q[i],
                                 e.inv);
                    end
                end
                n_tests++;
                if ({q1, qb1, inv1} !== {e.q[0][0], ~e.q[0][0], e.inv[0]}) begin
                    n_fail++;
                    $display("FAIL %s w1 edge%0d: Q/Qbar/inv got %b%b%b exp %b%b%b", e.name, k,
                             q1, qb1, inv1, e.q[0][0], ~e.q[0][0], e.inv[0]);
                end
            end
        end
    endtask

    task automatic test_both_high;
        exp_t e;
        logic [3:0] sv [5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        logic [3:0] rv [5] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h0};
        for (int k = 0; k < 5; k++) begin
            drive_edge("both_high", sv[k], rv[k]);
            e = sb.pop_front();
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if ({q4[i], qb4[i], inv4[i]} !== {e.q[i], ~e.q[i], e.inv}) begin
                    n_fail++;
                    $display("FAIL %s m%0d step%0d: Q/Qbar/inv got %b/%b/%b exp %b/%b/%b",
                             e.name, modes[i], k, q4[i], qb4[i], inv4[i], e.q[i], ~e.q[i],
                             e.inv);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        drive_edge("pre_async_set", 4'hF, 4'h0);
        e = sb.pop_front();
        n_tests++;
        if (q4[0] !== e.q[0]) begin
            n_fail++;
            $display("FAIL %s: Q got %b exp %b", e.name, q4[0], e.q[0]);
        end
        #4 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({q4[i], qb4[i], inv4[i]} !== {4'h0, 4'hF, 4'h0}) begin
                n_fail++;
                $display("FAIL async_pulse m%0d: Q/Qbar/inv got %b/%b/%b exp 0000/1111/0000",
                         modes[i], q4[i], qb4[i], inv4[i]);
            end
        end
        n_tests++;
        if ({q1, qb1} !== 2'b01) begin
            n_fail++;
            $display("FAIL async_pulse w1: Q/Qbar got %b%b exp 01", q1, qb1);
        end
        #2 rst_n = 1'b1;
        #1;
        n_tests++;
        if (q4[1] !== 4'h0) begin
            n_fail++;
            $display("FAIL async_release_hold: Q got %b exp 0000", q4[1]);
        end
        // Reset held across an edge with S=1 pending wins over the set.
        @(negedge clk);
        s = 4'hF;
        r = 4'h0;
        #9 rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (q4[i] !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_over_set m%0d: Q got %b exp 0000", modes[i], q4[i]);
            end
        end
        for (int i = 0; i < 5; i++) mq[i] = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_independent;
        exp_t e;
        drive_edge("independent", 4'b0101, 4'b1010);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({q4[i], qb4[i], inv4[i]} !== {e.q[i], ~e.q[i], e.inv}) begin
                n_fail++;
                $display("FAIL %s m%0d: Q/Qbar/inv got %b/%b/%b exp %b/%b/%b", e.name, modes[i],
                         q4[i], qb4[i], inv4[i], e.q[i], ~e.q[i], e.inv);
            end
        end
        n_tests++;
        if ({q4[0], qb4[0]} !== 8'b0101_1010) begin
            n_fail++;
            $display("FAIL independent_literal: Q/Qbar got %b/%b exp 0101/1010", q4[0], qb4[0]);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        for (int k = 0; k < 60; k++) begin
            drive_edge("back_to_back", 4'($urandom), 4'($urandom));
            e = sb.pop_front();
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if ({q4[i], qb4[i], inv4[i]} !== {e.q[i], ~e.q[i], e.inv}) begin
                    n_fail++;
                    $display("FAIL %s m%0d step%0d: Q/Qbar/inv got %b/%b/%b exp %b/%b/%b",
                             e.name, modes[i], k, q4[i], qb4[i], inv4[i], e.q[i], ~e.q[i],
                             e.inv);
                end
            end
            n_tests++;
            if ({q1, qb1, inv1} !== {e.q[0][0], ~e.q[0][0], e.inv[0]}) begin
                n_fail++;
                $display("FAIL %s w1 step%0d: Q/Qbar/inv got %b%b%b exp %b%b%b", e.name, k, q1,
                         qb1, inv1, e.q[0][0], ~e.q[0][0], e.inv[0]);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left exp 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) mq[i] = 4'h0;
        s = 4'h0;
        r = 4'h0;
        test_reset();
        test_set_reset_hold();
        test_both_high();
        test_async_reset();
        test_independent();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
